// File: rtl/switch_box_cfg.sv
// Wilton switch box routing W tracks between N/E/S/W and into the LE cluster,
// configured through a double-buffered serial chain committed atomically.
module switch_box_cfg #(
   parameter int CHANNEL_WIDTH    = 2,
   parameter int LE_OUTPUTS       = 1,
   parameter int LE_INPUTS        = 2,
   parameter int REGISTER_OUTPUTS = 0
) (
   input  logic                     clock,
   input  logic                     nreset,
   input  logic [CHANNEL_WIDTH-1:0] data_north_in,
   input  logic [CHANNEL_WIDTH-1:0] data_east_in,
   input  logic [CHANNEL_WIDTH-1:0] data_south_in,
   input  logic [CHANNEL_WIDTH-1:0] data_west_in,
   output logic [CHANNEL_WIDTH-1:0] data_north_out,
   output logic [CHANNEL_WIDTH-1:0] data_east_out,
   output logic [CHANNEL_WIDTH-1:0] data_south_out,
   output logic [CHANNEL_WIDTH-1:0] data_west_out,
   input  logic [LE_OUTPUTS-1:0]    data_from_les,
   output logic [LE_INPUTS-1:0]     data_to_les,
   input  logic                     config_in,
   input  logic                     config_enable,
   input  logic                     config_commit,
   output logic                     config_out,
   output logic                     config_valid,
   output logic                     config_error
);
   localparam int W            = CHANNEL_WIDTH;
   localparam int L            = LE_OUTPUTS;
   localparam int SEL_SIDE     = $clog2(L + 3);
   localparam int SEL_LE       = $clog2(L + 4 * W);
   localparam int CONFIG_WIDTH = 4 * W * SEL_SIDE + LE_INPUTS * SEL_LE;
   localparam int CNT_W        = $clog2(CONFIG_WIDTH + 1);
   localparam int SIDE_SRC     = 2 ** SEL_SIDE;
   localparam int LE_SRC       = 2 ** SEL_LE;

   logic [CONFIG_WIDTH-1:0] shadow;
   logic [CONFIG_WIDTH-1:0] active;
   logic [CNT_W-1:0]        bit_count;
   logic [4*W-1:0]          track_in;
   logic [4*W-1:0]          side_route;
   logic [4*W-1:0]          side_q;
   logic [LE_INPUTS-1:0]    le_route;
   logic [LE_INPUTS-1:0]    le_q;

   // Side order 0..3 = north, east, south, west, matching the config layout.
   assign track_in = {data_west_in, data_south_in, data_east_in, data_north_in};

   // NOTE: configuration is plain flops, not a memory, so every bit gets the async reset
   // and a reset mid-shift leaves no partial pattern behind.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         shadow       <= '0;
         active       <= '0;
         bit_count    <= '0;
         config_valid <= 1'b0;
         config_error <= 1'b0;
      end else begin
         // NOTE: non-blocking so commit copies the shadow value from before this edge.
         config_error <= 1'b0;
         if (config_commit) begin
            bit_count <= '0;
            if (bit_count == CNT_W'(CONFIG_WIDTH)) begin
               active       <= shadow;
               config_valid <= 1'b1;
            end else begin
               config_error <= 1'b1;
            end
         end else if (config_enable) begin
            shadow <= {shadow[CONFIG_WIDTH-2:0], config_in};
            if (bit_count != CNT_W'(CONFIG_WIDTH))
               bit_count <= bit_count + CNT_W'(1);
         end
      end
   end

   assign config_out = shadow[CONFIG_WIDTH-1];

   // Each side mux sees: LE outputs, then the clockwise neighbour (A), the opposite
   // side (B) and the anticlockwise neighbour (C); N/S and E/W swap the index twists.
   for (genvar d = 0; d < 4; d++) begin : g_side
      for (genvar i = 0; i < W; i++) begin : g_track
         localparam int ROT = (W - i) % W;
         localparam int NXT = (i + 1) % W;
         localparam int IA  = (d % 2 == 0) ? ROT : NXT;
         localparam int IC  = (d % 2 == 0) ? NXT : ROT;
         localparam int SA  = (d + 1) % 4;
         localparam int SB  = (d + 2) % 4;
         localparam int SC  = (d + 3) % 4;
         logic [SEL_SIDE-1:0] sel;
         logic [SIDE_SRC-1:0] src;
         assign sel = active[(d*W+i)*SEL_SIDE +: SEL_SIDE];
         assign src = SIDE_SRC'({track_in[SC*W+IC], track_in[SB*W+i],
                                 track_in[SA*W+IA], data_from_les});
         assign side_route[d*W+i] = src[sel] & config_valid;
      end
   end

   for (genvar j = 0; j < LE_INPUTS; j++) begin : g_le
      logic [SEL_LE-1:0] sel;
      logic [LE_SRC-1:0] src;
      assign sel = active[4*W*SEL_SIDE + j*SEL_LE +: SEL_LE];
      // Zero-extension makes every out-of-range select read 0.
      assign src = LE_SRC'({data_north_in, data_east_in, data_south_in,
                            data_west_in, data_from_les});
      assign le_route[j] = src[sel] & config_valid;
   end

   if (REGISTER_OUTPUTS != 0) begin : g_reg
      always_ff @(posedge clock or negedge nreset) begin
         if (!nreset) begin
            side_q <= '0;
            le_q   <= '0;
         end else begin
            side_q <= side_route;
            le_q   <= le_route;
         end
      end
   end else begin : g_comb
      assign side_q = side_route;
      assign le_q   = le_route;
   end

   assign data_north_out = side_q[0*W +: W];
   assign data_east_out  = side_q[1*W +: W];
   assign data_south_out = side_q[2*W +: W];
   assign data_west_out  = side_q[3*W +: W];
   assign data_to_les    = le_q;

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed bench for switch_box_cfg: one combinational and one registered
// instance share all inputs; expected values are hand-derived per vector.
module tb_switch_box_cfg;
   logic       clock = 1'b0;
   logic       nreset = 1'b0;
   logic [1:0] north_in = '0, east_in = '0, south_in = '0, west_in = '0;
   logic [0:0] from_les = '0;
   logic       config_in = 1'b0, config_enable = 1'b0, config_commit = 1'b0;

   logic [1:0] c_north, c_east, c_south, c_west, c_to_les;
   logic       c_cout, c_valid, c_error;
   logic [1:0] r_north, r_east, r_south, r_west, r_to_les;
   logic       r_cout, r_valid, r_error;

   int n_tests = 0;
   int n_fail  = 0;
   logic [23:0] cfg;
   logic        pat [48];

   always #5 clock = ~clock;

   switch_box_cfg #(.REGISTER_OUTPUTS(0)) dut_comb (
      .clock(clock), .nreset(nreset),
      .data_north_in(north_in), .data_east_in(east_in),
      .data_south_in(south_in), .data_west_in(west_in),
      .data_north_out(c_north), .data_east_out(c_east),
      .data_south_out(c_south), .data_west_out(c_west),
      .data_from_les(from_les), .data_to_les(c_to_les),
      .config_in(config_in), .config_enable(config_enable),
      .config_commit(config_commit), .config_out(c_cout),
      .config_valid(c_valid), .config_error(c_error));

   switch_box_cfg #(.REGISTER_OUTPUTS(1)) dut_reg (
      .clock(clock), .nreset(nreset),
      .data_north_in(north_in), .data_east_in(east_in),
      .data_south_in(south_in), .data_west_in(west_in),
      .data_north_out(r_north), .data_east_out(r_east),
      .data_south_out(r_south), .data_west_out(r_west),
      .data_from_les(from_les), .data_to_les(r_to_les),
      .config_in(config_in), .config_enable(config_enable),
      .config_commit(config_commit), .config_out(r_cout),
      .config_valid(r_valid), .config_error(r_error));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Shifts w[nbits-1:0] MSB first.
   task automatic shift_bits(input logic [23:0] w, input int nbits);
      for (int b = nbits - 1; b >= 0; b--) begin
         config_in     = w[b];
         config_enable = 1'b1;
         tick();
      end
      config_enable = 1'b0;
      config_in     = 1'b0;
   endtask

   task automatic commit();
      config_commit = 1'b1;
      tick();
      config_commit = 1'b0;
   endtask

   task automatic drive(input logic [1:0] n, input logic [1:0] e, input logic [1:0] s,
                        input logic [1:0] w, input logic les);
      north_in = n; east_in = e; south_in = s; west_in = w; from_les[0] = les;
      #1;
   endtask

   initial begin
      // Reset with live inputs: everything must still read 0.
      drive(2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
      tick();
      check("rst_north", c_north, 0);
      check("rst_east", c_east, 0);
      check("rst_south", c_south, 0);
      check("rst_west", c_west, 0);
      check("rst_to_les", c_to_les, 0);
      check("rst_cout", c_cout, 0);
      check("rst_valid", c_valid, 0);
      check("rst_error", c_error, 0);
      check("rst_reg_north", r_north, 0);
      nreset = 1'b1;
      tick();

      // North mux0 sel=2 -> south_in[0]; all else sel 0 -> from_les.
      drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      cfg = '0;
      cfg[1:0] = 2'd2;
      shift_bits(cfg, 24);
      check("pre_commit_valid", c_valid, 0);
      check("pre_commit_north", c_north, 0);
      commit();
      check("commit_valid", c_valid, 1);
      check("commit_north", c_north, 2'b01);
      check("commit_error", c_error, 0);
      check("reg_north_lat0", r_north, 2'b00);
      tick();
      check("reg_north_lat1", r_north, 2'b01);
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      check("toggle_comb_lo", c_north, 2'b00);
      check("toggle_reg_hold", r_north, 2'b01);
      tick();
      check("toggle_reg_lo", r_north, 2'b00);
      drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      check("toggle_reg_hold0", r_north, 2'b00);
      tick();
      check("toggle_reg_hi", r_north, 2'b01);

      // Rotation coverage across all four sides and both LE muxes.
      cfg = '0;
      cfg[3:2]   = 2'd1;  // north1 <- east_in[1]
      cfg[5:4]   = 2'd3;  // east0  <- north_in[0]
      cfg[7:6]   = 2'd2;  // east1  <- west_in[1]
      cfg[11:10] = 2'd3;  // south1 <- east_in[0]
      cfg[13:12] = 2'd1;  // west0  <- north_in[1]
      cfg[19:16] = 4'd8;  // le0    <- north_in[1]
      cfg[23:20] = 4'd5;  // le1    <- east_in[0]
      shift_bits(cfg, 24);
      commit();
      drive(2'b10, 2'b01, 2'b00, 2'b10, 1'b1);
      check("p1_north", c_north, 2'b01);
      check("p1_east", c_east, 2'b10);
      check("p1_south", c_south, 2'b11);
      check("p1_west", c_west, 2'b11);
      check("p1_to_les", c_to_les, 2'b11);
      drive(2'b01, 2'b10, 2'b11, 2'b01, 1'b0);
      check("p2_north", c_north, 2'b10);
      check("p2_east", c_east, 2'b01);
      check("p2_south", c_south, 2'b00);
      check("p2_west", c_west, 2'b00);
      check("p2_to_les", c_to_les, 2'b00);

      // Short shift then commit: one-cycle error, routing and valid kept.
      shift_bits(24'hFFFFFF, 23);
      commit();
      check("short_error", c_error, 1);
      check("short_valid", c_valid, 1);
      check("short_east", c_east, 2'b01);
      check("short_north", c_north, 2'b10);
      tick();
      check("short_error_clr", c_error, 0);

      // config_out is the input stream delayed by the chain length.
      for (int k = 0; k < 48; k++) pat[k] = (k % 4 != 1);
      for (int k = 0; k < 48; k++) begin
         config_in     = pat[k];
         config_enable = 1'b1;
         tick();
         if (k >= 23) check($sformatf("chain_out_%0d", k), c_cout, pat[k-23]);
      end
      config_enable = 1'b0;

      // All-zero config: every output follows from_les.
      drive(2'b00, 2'b00, 2'b10, 2'b00, 1'b1);
      shift_bits(24'h000000, 24);
      commit();
      check("le_sel0", c_to_les, 2'b11);
      check("le_sel0_north", c_north, 2'b11);

      // le0 sel=15 reads 0; le1 sel=4 -> south_in[1]; shadow MSB 0, next bit 1.
      cfg = '0;
      cfg[19:16] = 4'd15;
      cfg[23:20] = 4'd4;
      shift_bits(cfg, 24);
      check("pre_dual_cout", c_cout, 0);
      config_in     = 1'b1;
      config_enable = 1'b1;
      config_commit = 1'b1;
      tick();
      config_enable = 1'b0;
      config_commit = 1'b0;
      config_in     = 1'b0;
      check("dual_no_shift", c_cout, 0);
      check("dual_error", c_error, 0);
      check("le_sel15", c_to_les, 2'b10);

      // Reset mid-shift discards the partial load and the bit count.
      shift_bits(24'hFFFFFF, 10);
      nreset = 1'b0;
      #1;
      check("mid_rst_valid", c_valid, 0);
      check("mid_rst_reg_valid", r_valid, 0);
      check("mid_rst_north", c_north, 0);
      check("mid_rst_reg_les", r_to_les, 0);
      check("mid_rst_cout", c_cout, 0);
      nreset = 1'b1;
      tick();
      shift_bits(24'hFFFFFF, 14);
      commit();
      check("post_rst_error", c_error, 1);
      check("post_rst_valid", c_valid, 0);
      check("post_rst_reg_error", r_error, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
